// File: rtl/multiboot_icap_seq.sv
`default_nettype none
// ============================================================================
// Module      : multiboot_icap_seq
// Description : Spartan-6 ICAP IPROG reboot sequencer with request sync,
//               per-request address latch and optional byte bit-swap.
//               Optional fallback words enabled by macro MBT_FALLBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multiboot_icap_seq #(
   parameter logic [7:0]  SPI_OPCODE      = 8'h6B,
   parameter logic [15:0] MODE_WORD       = 16'h3100,
   parameter int          NOOP_COUNT      = 4,
   parameter int          REQ_SYNC_STAGES = 3,
   parameter bit          BIT_SWAP        = 1'b1
) (
   input  logic        CLK,
   input  logic        MBT_RESET_N,
   input  logic        MBT_REBOOT,
   input  logic [23:0] MBT_ADDR,
   input  logic [23:0] MBT_FB_ADDR,
   output logic        MBT_BUSY,
   output logic        MBT_DONE,
   output logic        ICAP_CE_N,
   output logic        ICAP_WR_N,
   output logic [15:0] ICAP_I
);

`ifdef MBT_FALLBACK_EN
   localparam logic [4:0] c_fb_words = 5'd4;
`else
   localparam logic [4:0] c_fb_words = 5'd0;
`endif
   localparam logic [4:0]  c_last_idx  = c_fb_words + 5'd12;
   localparam logic [3:0]  c_noop_load = 4'(NOOP_COUNT);
   localparam logic [15:0] c_noop_word = 16'h2000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEQ  = 2'd1,
      ST_NOOP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                       r_state;
   logic [REQ_SYNC_STAGES-1:0]   r_sync;
   logic                         r_edge;
   logic [4:0]                   r_idx;
   logic [3:0]                   r_noop_cnt;
   logic [23:0]                  r_addr;
   logic                         w_req_edge;
   logic                         w_idx_ok;
   logic [15:0]                  w_seq_word;
   logic [15:0]                  w_raw_word;
   logic [15:0]                  w_icap_word;

`ifdef MBT_FALLBACK_EN
   logic [23:0]                  r_fb_addr;
`else
   logic                         w_unused_fb;
   assign w_unused_fb = ^MBT_FB_ADDR;
`endif

   assign w_req_edge = r_sync[REQ_SYNC_STAGES-1] & ~r_edge;

   // IPROG command stream indexed by r_idx; fallback words shift the tail by c_fb_words
   always_comb begin
      w_seq_word = 16'hFFFF;
      w_idx_ok   = 1'b1;
      case (r_idx)
         5'd0:                 w_seq_word = 16'hFFFF;
         5'd1:                 w_seq_word = 16'hAA99;
         5'd2:                 w_seq_word = 16'h5566;
         5'd3:                 w_seq_word = 16'h30A1;
         5'd4:                 w_seq_word = 16'h0000;
`ifdef MBT_FALLBACK_EN
         5'd5:                 w_seq_word = 16'h32A1;
         5'd6:                 w_seq_word = r_fb_addr[15:0];
         5'd7:                 w_seq_word = 16'h32C1;
         5'd8:                 w_seq_word = {SPI_OPCODE, r_fb_addr[23:16]};
`endif
         c_fb_words + 5'd5:    w_seq_word = 16'h3261;
         c_fb_words + 5'd6:    w_seq_word = r_addr[15:0];
         c_fb_words + 5'd7:    w_seq_word = 16'h3281;
         c_fb_words + 5'd8:    w_seq_word = {SPI_OPCODE, r_addr[23:16]};
         c_fb_words + 5'd9:    w_seq_word = 16'h3301;
         c_fb_words + 5'd10:   w_seq_word = MODE_WORD;
         c_fb_words + 5'd11:   w_seq_word = 16'h30A1;
         c_fb_words + 5'd12:   w_seq_word = 16'h000E;
         default:              w_idx_ok   = 1'b0;
      endcase
   end

   assign w_raw_word = (r_state == ST_NOOP) ? c_noop_word : w_seq_word;

   // ICAP reads D0 first within each byte, so the swap mirrors bits per byte
   generate
      if (BIT_SWAP) begin : g_swap
         for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign w_icap_word[gi]     = w_raw_word[7-gi];
            assign w_icap_word[8+gi]   = w_raw_word[15-gi];
         end
      end else begin : g_pass
         assign w_icap_word = w_raw_word;
      end
   endgenerate

   always_ff @(posedge CLK or negedge MBT_RESET_N) begin
      if (!MBT_RESET_N) begin
         r_state    <= ST_IDLE;
         r_sync     <= '0;
         r_edge     <= 1'b0;
         r_idx      <= 5'd0;
         r_noop_cnt <= 4'd0;
         r_addr     <= 24'd0;
`ifdef MBT_FALLBACK_EN
         r_fb_addr  <= 24'd0;
`endif
         MBT_BUSY   <= 1'b0;
         MBT_DONE   <= 1'b0;
         ICAP_CE_N  <= 1'b1;
         ICAP_WR_N  <= 1'b1;
         ICAP_I     <= 16'hFFFF;
      end else begin
         r_sync    <= {r_sync[REQ_SYNC_STAGES-2:0], MBT_REBOOT};
         r_edge    <= r_sync[REQ_SYNC_STAGES-1];
         MBT_DONE  <= 1'b0;
         ICAP_CE_N <= 1'b1;
         ICAP_WR_N <= 1'b1;
         ICAP_I    <= 16'hFFFF;
         case (r_state)
            ST_IDLE: begin
               MBT_BUSY <= 1'b0;
               if (w_req_edge) begin
                  r_addr   <= MBT_ADDR;
`ifdef MBT_FALLBACK_EN
                  r_fb_addr <= MBT_FB_ADDR;
`endif
                  MBT_BUSY <= 1'b1;
                  r_idx    <= 5'd0;
                  r_state  <= ST_SEQ;
               end
            end
            ST_SEQ: begin
               if (!w_idx_ok) begin
                  MBT_BUSY <= 1'b0;
                  r_state  <= ST_IDLE;
               end else begin
                  ICAP_CE_N <= 1'b0;
                  ICAP_WR_N <= 1'b0;
                  ICAP_I    <= w_icap_word;
                  if (r_idx == c_last_idx) begin
                     r_noop_cnt <= c_noop_load;
                     r_state    <= ST_NOOP;
                  end else begin
                     r_idx <= r_idx + 5'd1;
                  end
               end
            end
            ST_NOOP: begin
               ICAP_CE_N <= 1'b0;
               ICAP_WR_N <= 1'b0;
               ICAP_I    <= w_icap_word;
               if (r_noop_cnt <= 4'd1) begin
                  r_state <= ST_DONE;
               end else begin
                  r_noop_cnt <= r_noop_cnt - 4'd1;
               end
            end
            ST_DONE: begin
               MBT_DONE <= 1'b1;
               r_state  <= ST_IDLE;
            end
            default: begin
               MBT_BUSY <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multiboot_icap_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiboot_icap_seq
// Description : Self-checking bench for multiboot_icap_seq (straight and
//               bit-swapped instances), honours MBT_FALLBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiboot_icap_seq;

   localparam int          c_sync  = 3;
   localparam int          c_noop  = 4;
   localparam logic [7:0]  c_opc   = 8'h6B;
   localparam logic [15:0] c_mode  = 16'h3100;
`ifdef MBT_FALLBACK_EN
   localparam bit          c_fb_en = 1'b1;
   localparam int          c_off   = 4;
`else
   localparam bit          c_fb_en = 1'b0;
   localparam int          c_off   = 0;
`endif
   localparam int          c_nw    = 13 + c_off + c_noop;

   typedef logic [15:0] wq_t[$];

   logic        clk;
   logic        MBT_RESET_N;
   logic        MBT_REBOOT;
   logic [23:0] MBT_ADDR;
   logic [23:0] MBT_FB_ADDR;
   logic        busy_ns, done_ns, ce_ns, wr_ns;
   logic [15:0] i_ns;
   logic        busy_sw, done_sw, ce_sw, wr_sw;
   logic [15:0] i_sw;

   multiboot_icap_seq #(.BIT_SWAP(1'b0)) u_dut_ns (
      .CLK(clk), .MBT_RESET_N(MBT_RESET_N), .MBT_REBOOT(MBT_REBOOT),
      .MBT_ADDR(MBT_ADDR), .MBT_FB_ADDR(MBT_FB_ADDR),
      .MBT_BUSY(busy_ns), .MBT_DONE(done_ns),
      .ICAP_CE_N(ce_ns), .ICAP_WR_N(wr_ns), .ICAP_I(i_ns));

   multiboot_icap_seq #(.BIT_SWAP(1'b1)) u_dut_sw (
      .CLK(clk), .MBT_RESET_N(MBT_RESET_N), .MBT_REBOOT(MBT_REBOOT),
      .MBT_ADDR(MBT_ADDR), .MBT_FB_ADDR(MBT_FB_ADDR),
      .MBT_BUSY(busy_sw), .MBT_DONE(done_sw),
      .ICAP_CE_N(ce_sw), .ICAP_WR_N(wr_sw), .ICAP_I(i_sw));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] swap16(input logic [15:0] w);
      logic [15:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i]   = w[7-i];
         r[8+i] = w[15-i];
      end
      return r;
   endfunction

   function automatic wq_t build_seq(input logic [23:0] a, input logic [23:0] fb);
      wq_t q;
      q = {};
      q.push_back(16'hFFFF); q.push_back(16'hAA99); q.push_back(16'h5566);
      q.push_back(16'h30A1); q.push_back(16'h0000);
      if (c_fb_en) begin
         q.push_back(16'h32A1); q.push_back(fb[15:0]);
         q.push_back(16'h32C1); q.push_back({c_opc, fb[23:16]});
      end
      q.push_back(16'h3261); q.push_back(a[15:0]);
      q.push_back(16'h3281); q.push_back({c_opc, a[23:16]});
      q.push_back(16'h3301); q.push_back(c_mode);
      q.push_back(16'h30A1); q.push_back(16'h000E);
      for (int i = 0; i < c_noop; i++) q.push_back(16'h2000);
      return q;
   endfunction

   // Model: timeline of expected outputs keyed by clock-edge number
   int          t = 0;
   int          next_free = 0;
   bit          hist [0:c_sync];
   logic [15:0] exp_word [int];
   bit          exp_busy [int];
   bit          exp_done [int];

   initial begin
      wq_t q;
      for (int i = 0; i <= c_sync; i++) hist[i] = 1'b0;
      forever begin
         @(posedge clk);
         t++;
         if (!MBT_RESET_N) begin
            exp_word.delete(); exp_busy.delete(); exp_done.delete();
            for (int i = 0; i <= c_sync; i++) hist[i] = 1'b0;
            next_free = 0;
         end else begin
            if (hist[c_sync-1] && !hist[c_sync] && t >= next_free) begin
               q = build_seq(MBT_ADDR, MBT_FB_ADDR);
               for (int i = 0; i < q.size(); i++) exp_word[t+1+i] = q[i];
               for (int i = 0; i <= q.size() + 1; i++) exp_busy[t+i] = 1'b1;
               exp_done[t+q.size()+1] = 1'b1;
               next_free = t + q.size() + 2;
            end
            for (int i = c_sync; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = MBT_REBOOT;
         end
      end
   end

   // Per-cycle compare and capture of written words
   logic [15:0] cap_ns[$];
   logic [15:0] cap_sw[$];
   int ce_cnt = 0, busy_cnt = 0, done_cnt = 0, first_ce_t = -1;

   initial begin
      bit          e_ce, e_busy, e_done;
      logic [15:0] e_data;
      forever begin
         @(posedge clk);
         #2;
         e_ce   = !exp_word.exists(t);
         e_data = e_ce ? 16'hFFFF : exp_word[t];
         e_busy = exp_busy.exists(t);
         e_done = exp_done.exists(t);
         check("cyc_ns", {12'd0, ce_ns, wr_ns, busy_ns, done_ns, i_ns},
                         {12'd0, e_ce, e_ce, e_busy, e_done, e_data});
         check("cyc_sw", {12'd0, ce_sw, wr_sw, busy_sw, done_sw, i_sw},
                         {12'd0, e_ce, e_ce, e_busy, e_done, swap16(e_data)});
         if (ce_ns === 1'b0) begin
            cap_ns.push_back(i_ns);
            ce_cnt++;
            if (first_ce_t < 0) first_ce_t = t;
         end
         if (ce_sw === 1'b0) cap_sw.push_back(i_sw);
         if (busy_ns === 1'b1) busy_cnt++;
         if (done_ns === 1'b1) done_cnt++;
      end
   end

   task automatic clear_cap();
      cap_ns.delete(); cap_sw.delete();
      ce_cnt = 0; busy_cnt = 0; done_cnt = 0; first_ce_t = -1;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done_cnt == 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_timeout"}, 32'(done_cnt != 0), 32'd1);
   endtask

   task automatic new_request(input logic [23:0] a, input logic [23:0] fb);
      MBT_REBOOT = 1'b0;
      repeat (c_sync + 2) @(negedge clk);
      MBT_ADDR    = a;
      MBT_FB_ADDR = fb;
      clear_cap();
      MBT_REBOOT  = 1'b1;
   endtask

   initial begin
      wq_t lit;
      int  rise_t;
      int  lat;
      int  n;
      MBT_RESET_N = 1'b0;
      MBT_REBOOT  = 1'b0;
      MBT_ADDR    = 24'd0;
      MBT_FB_ADDR = 24'd0;
      repeat (3) @(negedge clk);
      check("rst_ce_n", 32'(ce_ns), 32'd1);
      check("rst_wr_n", 32'(wr_ns), 32'd1);
      check("rst_icap_i", 32'(i_ns), 32'hFFFF);
      check("rst_busy", 32'(busy_ns), 32'd0);
      check("rst_done", 32'(done_ns), 32'd0);
      MBT_RESET_N = 1'b1;
      repeat (4) @(negedge clk);

      // Basic sequence, both bit orders
      clear_cap();
      MBT_ADDR   = 24'h120000;
      rise_t     = t;
      MBT_REBOOT = 1'b1;
      wait_done("seq1");
      repeat (4) @(negedge clk);
      check("seq1_ce_cycles", 32'(ce_cnt), 32'(c_nw));
      check("seq1_busy_cycles", 32'(busy_cnt), 32'(c_nw + 2));
      check("seq1_done_pulses", 32'(done_cnt), 32'd1);
      lat = first_ce_t - rise_t;
      check("seq1_latency_in_range", 32'(lat >= c_sync + 2 && lat <= c_sync + 4), 32'd1);
      lit = {16'hFFFF, 16'hAA99, 16'h5566, 16'h30A1, 16'h0000};
`ifdef MBT_FALLBACK_EN
      lit = {lit, 16'h32A1, 16'h0000, 16'h32C1, 16'h6B00};
`endif
      lit = {lit, 16'h3261, 16'h0000, 16'h3281, 16'h6B12, 16'h3301, 16'h3100,
             16'h30A1, 16'h000E, 16'h2000, 16'h2000, 16'h2000, 16'h2000};
      for (int i = 0; i < lit.size(); i++)
         check($sformatf("seq1_word%0d", i), 32'(cap_ns[i]), 32'(lit[i]));
      check("swap_aa99", 32'(cap_sw[1]), 32'h5599);
      check("swap_6b12", 32'(cap_sw[c_off + 8]), 32'hD648);
      check("swap_noop", 32'(cap_sw[c_nw - 1]), 32'h0400);

      // Second edge while busy and address change after accept
      new_request(24'h345678, 24'hABCDEF);
      repeat (8) @(negedge clk);
      MBT_ADDR    = 24'hFFFFFF;
      MBT_FB_ADDR = 24'h111111;
      MBT_REBOOT  = 1'b0;
      repeat (2) @(negedge clk);
      MBT_REBOOT  = 1'b1;
      wait_done("seq2");
      // Level held high across two sequences' worth of cycles
      repeat (2 * c_nw + 10) @(negedge clk);
      check("seq2_done_pulses", 32'(done_cnt), 32'd1);
      check("seq2_ce_cycles", 32'(ce_cnt), 32'(c_nw));
      check("seq2_gen1", 32'(cap_ns[c_off + 6]), 32'h5678);
      check("seq2_gen2", 32'(cap_ns[c_off + 8]), 32'h6B34);
`ifdef MBT_FALLBACK_EN
      check("seq2_gen3", 32'(cap_ns[6]), 32'hCDEF);
      check("seq2_gen4", 32'(cap_ns[8]), 32'h6BAB);
`endif

      // Low-then-high edge starts the next sequence
      new_request(24'h300000, 24'h000000);
      wait_done("seq3");
      repeat (3) @(negedge clk);
      check("seq3_ce_cycles", 32'(ce_cnt), 32'(c_nw));
      check("seq3_busy_cycles", 32'(busy_cnt), 32'(c_nw + 2));
      check("seq3_gen2", 32'(cap_ns[c_off + 8]), 32'h6B30);
`ifdef MBT_FALLBACK_EN
      check("seq3_fb_words", {cap_ns[5], cap_ns[6]}, 32'h32A1_0000);
      check("seq3_fb_words2", {cap_ns[7], cap_ns[8]}, 32'h32C1_6B00);
`endif

      // Reset while word index 7 is being selected
      new_request(24'h120000, 24'h000000);
      n = 0;
      while (cap_ns.size() < 7 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_reach_idx7", 32'(cap_ns.size()), 32'd7);
      MBT_RESET_N = 1'b0;
      #1;
      check("rst_mid_ce_n", 32'({ce_ns, wr_ns, ce_sw, wr_sw}), 32'hF);
      check("rst_mid_icap_i", 32'(i_ns), 32'hFFFF);
      check("rst_mid_busy", 32'({busy_ns, busy_sw, done_ns}), 32'd0);
      repeat (2) @(negedge clk);
      MBT_REBOOT  = 1'b0;
      repeat (2) @(negedge clk);
      MBT_RESET_N = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mid_no_more_words", 32'(cap_ns.size()), 32'd7);
      new_request(24'h120000, 24'h000000);
      wait_done("seq4");
      repeat (3) @(negedge clk);
      check("seq4_ce_cycles", 32'(ce_cnt), 32'(c_nw));
      check("seq4_done_pulses", 32'(done_cnt), 32'd1);
      check("seq4_first_word", 32'(cap_ns[0]), 32'hFFFF);
      check("seq4_last_word", 32'(cap_ns[c_nw - 1]), 32'h2000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/multiboot_icap_seq.md
Name: multiboot_icap_seq

Overview:
- Parametrised ICAP reboot sequencer; successor to the fixed Spartan-6 multiboot FSM.
- On a synchronised rising edge of a reboot request, it emits a Spartan-6 IPROG command stream over a 16-bit ICAP write port:
  - boot address in GENERAL_1/2;
  - optional golden fallback address in GENERAL_3/4;
  - MODE word, then a configurable NOOP tail.
- ICAP primitive is instantiated by the parent, so the sequence is fully observable in simulation.
- Adds busy/done handshake, request synchroniser, per-request address latch and selectable byte bit-swap.

Parameters:
- SPI_OPCODE, 8'h6B: SPI read opcode placed in the high byte of GENERAL_2/GENERAL_4.
- MODE_WORD, 16'h3100: data written to the MODE register.
- NOOP_COUNT, 4: NOOP words (16'h2000) after IPROG; legal range 1..15.
- REQ_SYNC_STAGES, 3: synchroniser flops on MBT_REBOOT; legal range 2..4.
- BIT_SWAP, 1:
  - 1 = reverse bit order within each byte of ICAP_I (D0 is read first);
  - 0 = pass straight through.

Ports:
- CLK  in  1  ICAP clock; all logic rises on this edge.
- MBT_RESET_N  in  1  asynchronous active-low reset.
- MBT_REBOOT  in  1  reboot request; level, asynchronous to CLK; only a rising edge triggers.
- MBT_ADDR  in  24  SPI boot address; sampled on request accept.
- MBT_FB_ADDR  in  24  golden fallback address; sampled on accept; ignored unless MBT_FALLBACK_EN.
- MBT_BUSY  out  1  high from accept until the end of the DONE state.
- MBT_DONE  out  1  one-cycle pulse after the last NOOP word.
- ICAP_CE_N  out  1  ICAP chip enable, active low, registered.
- ICAP_WR_N  out  1  ICAP write, active low (0 = write), registered.
- ICAP_I  out  16  ICAP data, registered, bit-swapped per BIT_SWAP.

Behaviour:
- Reset (async assert, sync release):
  - MBT_BUSY = 0, MBT_DONE = 0;
  - ICAP_CE_N = 1, ICAP_WR_N = 1, ICAP_I = 16'hFFFF;
  - state = IDLE, synchroniser = 0.
- Reset mid-sequence aborts immediately, with no partial word completion.
- Request path:
  - MBT_REBOOT passes through REQ_SYNC_STAGES flops, then one edge flop.
  - req_edge = sync_out & ~edge_ff.
  - req_edge in IDLE → accept: latch MBT_ADDR/MBT_FB_ADDR, set MBT_BUSY next cycle, state = SEQ, index = 0.
  - req_edge while not IDLE → ignored and not queued.
  - A level held high after completion does not retrigger; it must go low and high again.
- States:
  - IDLE → SEQ on accept.
  - SEQ: one word per cycle, index 0..LAST:
    - 16'hFFFF, AA99, 5566, 30A1, 0000;
    - [fallback only: 32A1, fb[15:0], 32C1, {SPI_OPCODE, fb[23:16]}];
    - 3261, addr[15:0], 3281, {SPI_OPCODE, addr[23:16]};
    - 3301, MODE_WORD, 30A1, 000E.
  - SEQ → NOOP after the 000E word.
  - NOOP: emits 16'h2000 for NOOP_COUNT cycles (4-bit down counter), then → DONE.
  - DONE: one cycle; CE_N/WR_N = 1, I = FFFF; MBT_DONE = 1; MBT_BUSY drops the following cycle; → IDLE.
- Word counts: 13 base words (17 with fallback) plus NOOP_COUNT.
- Output register: the word selected in cycle N appears on ICAP_I with CE_N = WR_N = 0 in cycle N+1. CE_N and WR_N always toggle together.
- Latency: MBT_REBOOT rise to first CE_N low = REQ_SYNC_STAGES + 3 CLK cycles, ±1 for input phase.
- Address is held in the latch for the whole sequence; input changes after accept have no effect.
- No back-pressure: ICAP is assumed always ready.
- Illegal state or index → IDLE with idle outputs.

Optional Feature:
- Macro: MBT_FALLBACK_EN.
- Defined: the 4 GENERAL_3/4 words are inserted after 0000 and before 3261; SEQ is 17 words.
- Undefined: no fallback words; MBT_FB_ADDR is unused (no latch synthesised); SEQ is 13 words.

Test Plan:
- Reset, then MBT_REBOOT 0→1 with MBT_ADDR = 24'h120000, defaults, BIT_SWAP = 0 → CE_N low for exactly 17 cycles; words FFFF, AA99, 5566, 30A1, 0000, 3261, 0000, 3281, 6B12, 3301, 3100, 30A1, 000E, 2000×4; one DONE pulse; BUSY high for 19 cycles.
- Same request with BIT_SWAP = 1 → AA99 appears as 5599 and 6B12 as D648; CE_N/WR_N timing unchanged.
- MBT_FALLBACK_EN defined, MBT_FB_ADDR = 24'h000000, MBT_ADDR = 24'h300000 → words 32A1, 0000, 32C1, 6B00 precede 3261; 21 written words in total.
- Second MBT_REBOOT pulse while BUSY, and MBT_ADDR changed mid-sequence → no restart; GENERAL_1/2 carry the originally latched address; exactly one DONE pulse.
- Assert MBT_RESET_N low at word index 7 → outputs go idle (CE_N = 1, I = FFFF) in the same cycle, BUSY = 0; a fresh request afterwards produces a complete sequence.
- MBT_REBOOT held high across two sequences' worth of cycles → only one sequence; a low-then-high edge starts the next.
